// File: rtl/uart_pkg.sv
// Shared encodings for the memory-mapped UART transmitter.
// No logic; state encoding, register word indices and STATUS bit positions.
package uart_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_START = 2'd1;
  localparam logic [1:0] ENC_DATA  = 2'd2;
  localparam logic [1:0] ENC_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    START = ENC_START,
    DATA  = ENC_DATA,
    STOP  = ENC_STOP
  } state_e;

  // Word index within the 8-byte window, i.e. addr[2].
  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; write visible on dout one edge after push, dout combinational.
// Push while full is dropped, pop while empty ignored; push+pop on one edge keeps count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 UART transmitter; a byte written to an idle, empty block starts its frame next edge.
// Writes to a full FIFO are dropped and latch a sticky overflow flag; the bus never stalls.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE         = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] dIn,
  output logic [31:0] dOut,
  output logic        sel,
  output logic        tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            overflow_q, overflow_d;

  logic            wr_txdata, wr_status;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            baud_end;
  logic            unused_bits;

  assign sel       = (addr[31:3] == BASE[31:3]);
  assign wr_txdata = we && sel && (addr[2] == REG_TXDATA);
  assign wr_status = we && sel && (addr[2] == REG_STATUS);
  assign baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign unused_bits = ^{addr[1:0], dIn[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (dIn[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A dropped push and a clear can never coincide: they target different words.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_txdata && fifo_full)          overflow_d = 1'b1;
    else if (wr_status && dIn[STAT_OVF]) overflow_d = 1'b0;
  end

  always_comb begin
    dOut = '0;
    if (sel && (addr[2] == REG_STATUS)) begin
      dOut[STAT_BUSY]                  = (state_q != IDLE);
      dOut[STAT_FULL]                  = fifo_full;
      dOut[STAT_EMPTY]                 = fifo_empty;
      dOut[STAT_OVF]                   = overflow_q;
      dOut[STAT_CNT_LSB+3:STAT_CNT_LSB] = 4'(fifo_count);
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx       = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus frame,
// back-to-back, overflow, mid-frame reset and out-of-window sequences.
module tb_mmio_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] dIn;
  logic [31:0] dOut;
  logic        sel;
  logic        tx;

  int n_vec = 0;
  int n_err = 0;

  mmio_uart_tx #(
    .BASE         (32'h0000_0100),
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .dIn   (dIn),
    .dOut  (dOut),
    .sel   (sel),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic        exp_sel;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Expected line level at cycle j of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    int slot;
    slot = j / CPB;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; dIn = d;
    tick();
    we = 1'b0; addr = 32'h104; dIn = '0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 32'h104; dIn = '0;

    vecs[0] = '{1'b0, 32'h0000_0104, 32'h0,   1'b1, 32'h0000_0004};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,   1'b1, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'h0000_0108, 32'hAA,  1'b0, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h0000_00FC, 32'h55,  1'b0, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0107, 32'h0,   1'b1, 32'h0000_0004};
    vecs[5] = '{1'b1, 32'h0000_0104, 32'h8,   1'b1, 32'h0000_0004};
    vecs[6] = '{1'b0, 32'h0000_00FF, 32'h0,   1'b0, 32'h0000_0000};
    vecs[7] = '{1'b0, 32'h0000_0104, 32'h0,   1'b1, 32'h0000_0004};

    tick(); tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_tx[%0d]", i), 32'(tx), 32'h1);
    end

    // Register access table; out-of-window writes must not push anything.
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; dIn = vecs[i].din;
      #1;
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_dout", i), dOut, vecs[i].exp_dout);
      tick();
      we = 1'b0; addr = 32'h104; dIn = '0;
      #1;
      check($sformatf("vec%0d_tx", i), 32'(tx), 32'h1);
      check($sformatf("vec%0d_status", i), dOut, 32'h4);
    end

    // Single frame of 0xA5.
    bus_write(32'h100, 32'hA5);
    #1;
    check("a5_status_e0", dOut, 32'h10);
    tick();
    for (int i = 0; i < 10*CPB; i++) begin
      #1;
      check($sformatf("a5_tx[%0d]", i), 32'(tx), 32'(frame_bit(8'hA5, i)));
      check($sformatf("a5_status[%0d]", i), dOut, 32'h5);
      tick();
    end
    #1;
    check("a5_status_end", dOut, 32'h4);
    check("a5_tx_end", 32'(tx), 32'h1);

    // Back-to-back frames: second write lands on the edge of the first pop.
    bus_write(32'h100, 32'h55);
    #1;
    check("b2b_status_e0", dOut, 32'h10);
    bus_write(32'h100, 32'h0F);
    for (int i = 0; i < 20*CPB; i++) begin
      #1;
      check($sformatf("b2b_tx[%0d]", i), 32'(tx),
            32'(frame_bit((i < 10*CPB) ? 8'h55 : 8'h0F, i % (10*CPB))));
      check($sformatf("b2b_status[%0d]", i), dOut, (i < 10*CPB) ? 32'h11 : 32'h05);
      tick();
    end
    #1;
    check("b2b_status_end", dOut, 32'h4);

    // Six writes in a row: one popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) bus_write(32'h100, 32'(8'h11 * (i + 1)));
    #1;
    // busy is set as well since the first byte's frame is in flight.
    check("ovf_status", dOut, 32'h4B);
    bus_write(32'h104, 32'h8);
    #1;
    check("ovf_clear", dOut, 32'h43);

    // Move into the data bits of the current frame, then reset.
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("pre_reset_status", dOut, 32'h43);
    reset = 1'b1;
    tick();
    check("reset_tx", 32'(tx), 32'h1);
    reset = 1'b0;
    #1;
    check("reset_status", dOut, 32'h4);
    for (int i = 0; i < 12*CPB; i++) begin
      tick();
      check($sformatf("post_reset_tx[%0d]", i), 32'(tx), 32'h1);
    end
    check("post_reset_status", dOut, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
